// File: rtl/ask_uart_deframer.sv
// 8N1 deframer for the demodulated ASK bit line, with a one-entry AXI-Stream style output register.
// Optional 2-of-3 majority sampling is enabled by defining ASK_DEFRAMER_MAJORITY_EN.
module ask_uart_deframer #(
    parameter int CPB_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 rx,
    input  logic [CPB_WIDTH-1:0] clks_per_bit,
    output logic [7:0]           o_tdata,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [CPB_WIDTH-1:0] CPB_MIN = CPB_WIDTH'(3'd4);
    localparam logic [CPB_WIDTH-1:0] CNT_ONE = CPB_WIDTH'(1'b1);
`ifdef ASK_DEFRAMER_MAJORITY_EN
    // Starting one count lower delays every decision by a cycle so the +1 neighbour is visible.
    localparam logic [CPB_WIDTH-1:0] CNT_LOAD = CPB_WIDTH'(1'b0);
`else
    localparam logic [CPB_WIDTH-1:0] CNT_LOAD = CNT_ONE;
`endif

    logic [2:0]           state_q, state_d;
    logic                 prev_rx_q, prev_rx_d;
    logic [CPB_WIDTH-1:0] n_q, n_d;
    logic [CPB_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
    logic [CPB_WIDTH-1:0] n_eff_s;
    logic [CPB_WIDTH-1:0] mid_s;
    logic                 sample_s;
    logic                 byte_done_s;
    logic                 load_s;
`ifdef ASK_DEFRAMER_MAJORITY_EN
    logic                 prev2_q, prev2_d;
`endif

    assign n_eff_s = (clks_per_bit < CPB_MIN) ? CPB_MIN : clks_per_bit;
    assign mid_s   = n_q >> 1;

    // Bit decision: majority of the last three line values, or the line itself.
    always_comb begin
`ifdef ASK_DEFRAMER_MAJORITY_EN
        sample_s = (rx & prev_rx_q) | (rx & prev2_q) | (prev_rx_q & prev2_q);
`else
        sample_s = rx;
`endif
    end

    // Receive FSM: start qualification, data shift, stop check and break wait.
    always_comb begin
        state_d     = state_q;
        prev_rx_d   = prev_rx_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_done_s = 1'b0;
        ferr_d      = 1'b0;
`ifdef ASK_DEFRAMER_MAJORITY_EN
        prev2_d     = prev2_q;
`endif
        if (enable) begin
            prev_rx_d = rx;
`ifdef ASK_DEFRAMER_MAJORITY_EN
            prev2_d   = prev_rx_q;
`endif
            case (state_q)
                S_IDLE: begin
                    if (!rx && prev_rx_q) begin
                        n_d     = n_eff_s;
                        cnt_d   = CNT_LOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (cnt_q == mid_s) begin
                        cnt_d   = CNT_ONE;
                        bit_d   = 3'd0;
                        state_d = sample_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (cnt_q == n_q) begin
                        cnt_d   = CNT_ONE;
                        shift_d = {sample_s, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (cnt_q == n_q) begin
                        byte_done_s = sample_s;
                        ferr_d      = ~sample_s;
                        state_d     = sample_s ? S_IDLE : S_BREAK;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_BREAK: begin
                    if (rx) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BREAK;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output holding register: a completed byte replaces the old one only if it is being taken.
    always_comb begin
        load_s  = byte_done_s & (~tvalid_q | o_tready);
        ovr_d   = byte_done_s & tvalid_q & ~o_tready;
        tdata_d = tdata_q;
        busy_d  = (state_d != S_IDLE);
        if (load_s) begin
            tdata_d  = shift_q;
            tvalid_d = 1'b1;
        end else if (o_tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // State registers with synchronous reset and soft clear.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state_q   <= S_IDLE;
            prev_rx_q <= 1'b1;
            n_q       <= CPB_MIN;
            cnt_q     <= CPB_WIDTH'(1'b0);
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            tdata_q   <= 8'h00;
            tvalid_q  <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ASK_DEFRAMER_MAJORITY_EN
            prev2_q   <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            prev_rx_q <= prev_rx_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
`ifdef ASK_DEFRAMER_MAJORITY_EN
            prev2_q   <= prev2_d;
`endif
        end
    end

    assign o_tdata       = tdata_q;
    assign o_tvalid      = tvalid_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;
    assign busy          = busy_q;

endmodule
